serial_pattern_gen: RTL and testbench

- Serial bit-stream transmitter: the source side of the serial-input Mealy sequence detectors.
- Accepts a parallel pattern word, length and repeat count over a valid/ready handshake.
- Emits the pattern MSB-first, one bit per clk, with a bit-valid strobe.
- Keeps a built-in count of overlapping "101" occurrences in the emitted stream, so a detector under test can be checked against it.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/serial_pattern_gen_if.sv | 41 ++++
 rtl/seq101_model.sv | 59 +++++
 rtl/serial_pattern_gen.sv | 138 +++++++++++++
 tb/tb_serial_pattern_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern generator and the "101" Mealy
// sequence detectors it drives.
//   state_e      : generator FSM states (IDLE -> SHIFT -> FINISH -> IDLE)
//   *_DEF        : default widths/sizes used by the generator and its bus
//   PATTERN_101  : the 3-bit sequence counted by the model and the detectors
// ----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int MAX_LEN_DEF = 16;
  localparam int LEN_W_DEF   = 5;
  localparam int REP_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;

  // Oldest bit on the left: history[1], history[0], current bit.
  localparam logic [2:0] PATTERN_101 = 3'b101;

endpackage

// File: rtl/serial_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// serial_pattern_gen_if
// Start handshake plus serial stream outputs of serial_pattern_gen.
//   start_valid/start_ready : run request handshake
//   pat_data/pat_len/pat_rep: pattern word, length in bits, repeat count
//   bit_out/bit_valid       : serial data and its strobe
//   busy/done               : run in progress / end-of-run pulse
//   exp_cnt                 : overlapping "101" count of the emitted stream
// master = requester side, slave = generator side.
// ----------------------------------------------------------------------------
interface serial_pattern_gen_if
  import seq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int REP_W   = REP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
);

  logic               start_valid;
  logic               start_ready;
  logic [MAX_LEN-1:0] pat_data;
  logic [LEN_W-1:0]   pat_len;
  logic [REP_W-1:0]   pat_rep;
  logic               bit_out;
  logic               bit_valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   exp_cnt;

  modport master (
    output start_valid, pat_data, pat_len, pat_rep,
    input  start_ready, bit_out, bit_valid, busy, done, exp_cnt
  );

  modport slave (
    input  start_valid, pat_data, pat_len, pat_rep,
    output start_ready, bit_out, bit_valid, busy, done, exp_cnt
  );

endinterface

// File: rtl/seq101_model.sv
// ----------------------------------------------------------------------------
// seq101_model
// Counts overlapping "101" occurrences in a bit stream. Usable both inside the
// generator and as a scoreboard reference for the detectors.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clears history and count (start of a new run)
//   bit_valid : bit_out carries a stream bit this cycle
//   bit_out   : stream bit
//   exp_cnt   : saturating match count
// ----------------------------------------------------------------------------
module seq101_model
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_out,
  output logic [CNT_W-1:0] exp_cnt
);

  logic [1:0]       hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (clr) begin
      hist_d = 2'b00;
      cnt_d  = '0;
    end else if (bit_valid) begin
      // History is only advanced by valid bits, so it spans repetition
      // boundaries but never crosses a clr.
      hist_d = {hist_q[0], bit_out};
      if ({hist_q, bit_out} == PATTERN_101) begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign exp_cnt = cnt_q;

endmodule

// File: rtl/serial_pattern_gen.sv
// ----------------------------------------------------------------------------
// serial_pattern_gen
// Serial bit-stream source for the "101" sequence detectors. A pattern word,
// length and repeat count are accepted over a valid/ready handshake and sent
// MSB-first (bit pat_len-1 first), one bit per clock, repetitions back to
// back with no gap. An internal seq101_model keeps the expected match count.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : serial_pattern_gen_if slave modport (handshake, pattern, stream,
//         busy/done status, exp_cnt)
// Latency: first bit the cycle after accept; done one cycle after last bit.
// ----------------------------------------------------------------------------
module serial_pattern_gen
  import seq_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int REP_W   = REP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_pattern_gen_if.slave  bus
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               bit_q, bit_d;
  logic               start_ready;
  logic               accept;
  logic               bit_valid;
  logic [CNT_W-1:0]   exp_cnt;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

  function automatic logic [REP_W-1:0] fix_rep(input logic [REP_W-1:0] r);
    return (r == '0) ? REP_W'(1) : r;
  endfunction

  // Mux-style bit select keeps the index width independent of MAX_LEN.
  function automatic logic pick_bit(input logic [MAX_LEN-1:0] w,
                                    input logic [LEN_W-1:0]   i);
    logic r;
    r = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (LEN_W'(k) == i) r = w[k];
    end
    return r;
  endfunction

  assign start_ready = (state_q == IDLE) && !rst;
  assign accept      = bus.start_valid && start_ready;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    bit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pat_d = bus.pat_data;
          len_d = clamp_len(bus.pat_len);
          rep_d = fix_rep(bus.pat_rep);
          if (len_d == '0) begin
            state_d = FINISH;
          end else begin
            // Preload the first bit so it appears the cycle after accept.
            state_d = SHIFT;
            idx_d   = len_d - LEN_W'(1);
            bit_d   = pick_bit(bus.pat_data, len_d - LEN_W'(1));
          end
        end
      end
      SHIFT: begin
        if (idx_q == '0) begin
          if (rep_q > REP_W'(1)) begin
            rep_d = rep_q - REP_W'(1);
            idx_d = len_q - LEN_W'(1);
            bit_d = pick_bit(pat_q, len_q - LEN_W'(1));
          end else begin
            state_d = FINISH;
          end
        end else begin
          idx_d = idx_q - LEN_W'(1);
          bit_d = pick_bit(pat_q, idx_q - LEN_W'(1));
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
    end
  end

  // Pattern, length, index and repeat count are only meaningful while the
  // state says so, so they carry no reset.
  always_ff @(posedge clk) begin
    pat_q <= pat_d;
    len_q <= len_d;
    idx_q <= idx_d;
    rep_q <= rep_d;
  end

  assign bit_valid = (state_q == SHIFT);

  seq101_model #(.CNT_W(CNT_W)) u_model (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .bit_valid (bit_valid),
    .bit_out   (bit_q),
    .exp_cnt   (exp_cnt)
  );

  assign bus.start_ready = start_ready;
  assign bus.bit_out     = bit_q;
  assign bus.bit_valid   = bit_valid;
  assign bus.busy        = (state_q == SHIFT);
  assign bus.done        = (state_q == FINISH);
  assign bus.exp_cnt     = exp_cnt;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_serial_pattern_gen
// Directed, table-driven bench for serial_pattern_gen. The counter width is
// reduced to 4 bits so that saturation is reachable in a short run.
// ----------------------------------------------------------------------------
module tb_serial_pattern_gen;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int REP_W   = 4;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_pattern_gen_if #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .CNT_W(CNT_W)
  ) bus ();

  serial_pattern_gen #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic [3:0]  rep;
    int          nbits;
    logic [63:0] stream;  // expected stream, first bit at position nbits-1
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int w;
    w = 0;
    while (!bus.start_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_ready"}, 64'(bus.start_ready), 64'd1);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [63:0] sh;
    string nm;
    nm = $sformatf("vec%0d", n);
    wait_ready(nm);
    bus.pat_data    = v.pat;
    bus.pat_len     = v.len;
    bus.pat_rep     = v.rep;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    for (int i = 0; i < v.nbits; i++) begin
      sh = v.stream >> (v.nbits - 1 - i);
      chk($sformatf("%s_bv%0d", nm, i), 64'(bus.bit_valid), 64'd1);
      chk($sformatf("%s_bit%0d", nm, i), 64'(bus.bit_out), 64'(sh[0]));
      chk($sformatf("%s_busy%0d", nm, i), 64'(bus.busy), 64'd1);
      @(negedge clk);
    end
    chk({nm, "_done"}, 64'(bus.done), 64'd1);
    chk({nm, "_bv_end"}, 64'(bus.bit_valid), 64'd0);
    chk({nm, "_bitout_end"}, 64'(bus.bit_out), 64'd0);
    chk({nm, "_busy_end"}, 64'(bus.busy), 64'd0);
    chk({nm, "_cnt"}, 64'(bus.exp_cnt), 64'(v.cnt));
    @(negedge clk);
    chk({nm, "_done_off"}, 64'(bus.done), 64'd0);
    chk({nm, "_ready_after"}, 64'(bus.start_ready), 64'd1);
    chk({nm, "_cnt_hold"}, 64'(bus.exp_cnt), 64'(v.cnt));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.pat_data    = '0;
    bus.pat_len     = '0;
    bus.pat_rep     = '0;

    //            pat       len    rep   n   stream                cnt
    vecs[0] = '{16'hFFF5, 5'd3,  4'd1, 3,  64'b101,              4'd1};
    vecs[1] = '{16'h0015, 5'd5,  4'd1, 5,  64'b10101,            4'd2};
    vecs[2] = '{16'h0002, 5'd2,  4'd3, 6,  64'b101010,           4'd2};
    vecs[3] = '{16'h0005, 5'd0,  4'd5, 0,  64'd0,                4'd0};
    vecs[4] = '{16'h0005, 5'd3,  4'd0, 3,  64'b101,              4'd1};
    vecs[5] = '{16'hAAAA, 5'd31, 4'd3, 48, 64'hAAAA_AAAA_AAAA,   4'd15};
    vecs[6] = '{16'h000B, 5'd4,  4'd2, 8,  64'b10111011,         4'd2};
    vecs[7] = '{16'h8001, 5'd16, 4'd1, 16, 64'h8001,             4'd0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.start_ready), 64'd0);
    chk("rst_bv", 64'(bus.bit_valid), 64'd0);
    chk("rst_bit", 64'(bus.bit_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cnt", 64'(bus.exp_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Back-to-back: request held high; the pattern change during the first
    // run must be ignored, and the second run must not see the first's bits.
    wait_ready("b2b");
    bus.pat_data    = 16'h0002;
    bus.pat_len     = 5'd2;
    bus.pat_rep     = 4'd1;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.pat_data = 16'h0001;
    bus.pat_len  = 5'd1;
    chk("b2b_bv0", 64'(bus.bit_valid), 64'd1);
    chk("b2b_bit0", 64'(bus.bit_out), 64'd1);
    @(negedge clk);
    chk("b2b_bit1", 64'(bus.bit_out), 64'd0);
    chk("b2b_busy_ready", 64'(bus.start_ready), 64'd0);
    @(negedge clk);
    chk("b2b_done1", 64'(bus.done), 64'd1);
    chk("b2b_cnt1", 64'(bus.exp_cnt), 64'd0);
    chk("b2b_fin_ready", 64'(bus.start_ready), 64'd0);
    @(negedge clk);
    chk("b2b_idle_ready", 64'(bus.start_ready), 64'd1);
    chk("b2b_idle_bv", 64'(bus.bit_valid), 64'd0);
    @(negedge clk);
    bus.start_valid = 1'b0;
    chk("b2b_run2_bv", 64'(bus.bit_valid), 64'd1);
    chk("b2b_run2_bit", 64'(bus.bit_out), 64'd1);
    @(negedge clk);
    chk("b2b_done2", 64'(bus.done), 64'd1);
    chk("b2b_cnt2", 64'(bus.exp_cnt), 64'd0);
    @(negedge clk);

    // Reset in the middle of a run: stream abandoned, no done pulse.
    wait_ready("mrst");
    bus.pat_data    = 16'h000B;
    bus.pat_len     = 5'd4;
    bus.pat_rep     = 4'd1;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    chk("mrst_bit0", 64'(bus.bit_out), 64'd1);
    @(negedge clk);
    chk("mrst_bit1", 64'(bus.bit_out), 64'd0);
    chk("mrst_bv1", 64'(bus.bit_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_bv", 64'(bus.bit_valid), 64'd0);
    chk("mrst_bit", 64'(bus.bit_out), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_done", 64'(bus.done), 64'd0);
    chk("mrst_cnt", 64'(bus.exp_cnt), 64'd0);
    chk("mrst_ready_in_rst", 64'(bus.start_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 64'(bus.start_ready), 64'd1);
    @(negedge clk);
    chk("mrst_no_done", 64'(bus.done), 64'd0);
    chk("mrst_bv_after", 64'(bus.bit_valid), 64'd0);

    // A normal run still works after the abort.
    run_vec(8, vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
